set_cmd_sched: RTL and testbench

- Command scheduler that sits directly upstream of the SET point-count core.
- Accepts tagged set-query commands from the host over a valid/ready interface and buffers them in a small FIFO.
- Issues commands one at a time to the core using its en/busy/valid protocol, then returns each tagged candidate count over a valid/ready result interface.
- Mode 2'b11 and core hangs are handled here, so the core never stalls the system.

---
 rtl/set_cmd_sched.sv | 164 ++++++++++++++++
 tb/tb_set_cmd_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_cmd_sched.sv
// set_cmd_sched: buffers tagged SET queries in a FIFO and runs them one at a time on the core, results in order.
// Optional watchdog on the WAIT state is built in with `define SET_WDOG_EN (limit TIMEOUT cycles).
module set_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [23:0]      cmd_central,
  input  logic [11:0]      cmd_radius,
  input  logic [1:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [7:0]       res_count,
  output logic             res_err
);
  localparam int AW = $clog2(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_bad_param
      $error("set_cmd_sched: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end
  endgenerate

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  state_t        state, state_nxt;
  logic          load, cap, err_done, res_clr, wdog_hit;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_central, cmd_radius, cmd_mode, cmd_tag};
  end

`ifdef SET_WDOG_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] wdog_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wdog_cnt <= '0;
    else if (state == ISSUE) wdog_cnt <= '0;
    else if (state == WAIT)  wdog_cnt <= wdog_cnt + 1'b1;
  end

  // Fires as the count steps onto TIMEOUT-1, so the result lands TIMEOUT cycles after en.
  assign wdog_hit = (wdog_cnt == CW'(TIMEOUT - 2));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    cap       = 1'b0;
    err_done  = 1'b0;
    res_clr   = 1'b0;
    set_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !res_valid && !set_busy) begin
          pop = 1'b1;
          if (head.mode == 2'b11) begin
            err_done  = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        set_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (set_valid) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end else if (wdog_hit) begin
          err_done  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_valid && res_ready) begin
          res_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_count   <= '0;
      res_err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        res_tag <= head.tag;
      end
      if (load) begin
        set_central <= head.central;
        set_radius  <= head.radius;
        set_mode    <= head.mode;
      end
      if (cap) begin
        res_count <= set_candidate;
        res_err   <= 1'b0;
        res_valid <= 1'b1;
      end
      if (err_done) begin
        res_count <= '0;
        res_err   <= 1'b1;
        res_valid <= 1'b1;
      end
      if (res_clr) res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_set_cmd_sched.sv
// Bench for set_cmd_sched: stub SET core plus an in-order queue model of issued commands and expected results.
module tb_set_cmd_sched;
  localparam int DEPTH = 4, TAG_W = 4, TIMEOUT = 128;

  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, set_en, set_busy, set_valid, res_valid, res_ready, res_err;
  logic [23:0] cmd_central, set_central;
  logic [11:0] cmd_radius, set_radius;
  logic [1:0]  cmd_mode, set_mode;
  logic [TAG_W-1:0] cmd_tag, res_tag;
  logic [7:0]  set_candidate, res_count;

  always #5 clk = ~clk;

  set_cmd_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_central(cmd_central), .cmd_radius(cmd_radius), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_count(res_count),
    .res_err(res_err));

  typedef struct packed {logic [23:0] c; logic [11:0] r; logic [1:0] m;} iss_t;
  typedef struct packed {logic [TAG_W-1:0] tag; logic [7:0] cnt; logic err;} res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  logic [TAG_W-1:0] got_tags[$];
  int checks = 0, errors = 0, en_count = 0;

  bit core_hold = 0, core_rand = 0, core_mute = 0, core_abort = 0, core_stray = 0, use_fixed = 0;
  int core_lat = 4;
  logic [7:0] fixed_cand = 8'd0;

  // Stand-in for the core's point count: any deterministic function of the fields, kept in 0..64.
  function automatic logic [7:0] cand_of(input logic [23:0] c, input logic [11:0] r);
    int s;
    s = int'(c[5:0]) + int'(c[11:6]) + int'(c[17:12]) + int'(r[5:0]);
    return 8'(s % 65);
  endfunction

  function automatic void model_push(input logic [23:0] c, input logic [11:0] r,
                                     input logic [1:0] m, input logic [TAG_W-1:0] t);
    if (m == 2'b11) res_q.push_back({t, 8'd0, 1'b1});
    else begin
      iss_q.push_back({c, r, m});
      res_q.push_back({t, (use_fixed ? fixed_cand : cand_of(c, r)), 1'b0});
    end
  endfunction

  // Core stub: latches on en, raises busy, strobes valid after a latency, drops busy a cycle later.
  bit busy_r, active, drop;
  int cnt;
  logic [7:0] cand;
  initial begin
    set_busy = 0; set_valid = 0; set_candidate = 0; busy_r = 0; active = 0; drop = 0; cnt = 0; cand = 0;
    forever begin
      @(posedge clk); #2;
      set_valid = 0;
      if (rst) begin busy_r = 0; active = 0; drop = 0; end
      else begin
        if (drop) begin busy_r = 0; drop = 0; end
        if (core_abort) begin busy_r = 0; active = 0; core_abort = 0; end
        if (core_stray) begin set_valid = 1; set_candidate = 8'd55; core_stray = 0; end
        if (set_en) begin
          busy_r = 1; active = !core_mute;
          cnt = core_rand ? int'($urandom_range(1, 8)) : core_lat;
          cand = use_fixed ? fixed_cand : cand_of(set_central, set_radius);
        end else if (active) begin
          cnt--;
          if (cnt == 0) begin set_valid = 1; set_candidate = cand; active = 0; drop = 1; end
        end
      end
      set_busy = busy_r | core_hold;
    end
  end

  // Scoreboard: every en must match the next issuable command, every accepted result the next expected one.
  bit prev_en = 0;
  iss_t e_iss;
  res_t e_res;
  always @(negedge clk) begin
    if (rst) prev_en = 0;
    else begin
      if (set_en) begin
        en_count++; checks++;
        if (prev_en || iss_q.size() == 0) begin
          errors++; $display("FAIL issue_unexpected prev_en=%0b queued=%0d required prev_en=0 queued>0", prev_en, iss_q.size());
        end else begin
          e_iss = iss_q.pop_front();
          if ({set_central, set_radius, set_mode} !== e_iss) begin
            errors++; $display("FAIL issue_fields got %h required %h", {set_central, set_radius, set_mode}, e_iss);
          end
        end
      end
      prev_en = set_en;
      if (res_valid && res_ready) begin
        checks++; got_tags.push_back(res_tag);
        if (res_q.size() == 0) begin
          errors++; $display("FAIL result_unexpected got %h required none", {res_tag, res_count, res_err});
        end else begin
          e_res = res_q.pop_front();
          if ({res_tag, res_count, res_err} !== e_res) begin
            errors++; $display("FAIL result tag/count/err got %h required %h", {res_tag, res_count, res_err}, e_res);
          end
        end
      end
    end
  end

  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [TAG_W-1:0] t);
    int n = 0;
    @(posedge clk); #2;
    cmd_valid = 1; cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_tag = t;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++; $display("FAIL push_accept tag=%0d ready=%0b required 1", t, cmd_ready);
      @(posedge clk); #2; cmd_valid = 0;
    end else model_push(c, r, m, t);
  endtask

  task automatic cmd_idle;
    @(posedge clk); #2; cmd_valid = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(posedge clk); #2; res_ready = 1;
    while ((res_q.size() != 0 || res_valid) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (res_q.size() != 0 || iss_q.size() != 0) begin
      errors++; $display("FAIL drain_%s pending results=%0d issues=%0d required 0", name, res_q.size(), iss_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 4;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); end
    if (set_en !== 1'b0) begin errors++; $display("FAIL reset_set_en got %b required 0", set_en); end
    if ({set_central, set_radius, set_mode} !== 38'd0) begin
      errors++; $display("FAIL reset_set_regs got %h required 0", {set_central, set_radius, set_mode});
    end
    if ({res_valid, res_tag, res_count, res_err} !== '0) begin
      errors++; $display("FAIL reset_result got %h required 0", {res_valid, res_tag, res_count, res_err});
    end
    @(posedge clk); #2; rst = 0;
  endtask

  task automatic test_single;
    int base, n;
    @(posedge clk); #2; res_ready = 0; use_fixed = 1; fixed_cand = 8'd13; core_lat = 64;
    base = en_count;
    push({6'd4, 6'd4, 6'd0, 6'd0}, {6'd2, 6'd0}, 2'b00, 4'd3);
    cmd_idle;
    n = 0;
    do begin @(negedge clk); n++; end while (!set_en && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 200);
    checks += 2;
    if (n != 65) begin errors++; $display("FAIL single_latency got %0d required 65", n); end
    if ({res_tag, res_count, res_err} !== {4'd3, 8'd13, 1'b0}) begin
      errors++; $display("FAIL single_result got %h required %h", {res_tag, res_count, res_err}, {4'd3, 8'd13, 1'b0});
    end
    wait_drain("single");
    use_fixed = 0; core_lat = 4;
    checks++;
    if (en_count - base != 1) begin errors++; $display("FAIL single_en_pulses got %0d required 1", en_count - base); end
  endtask

  task automatic test_illegal;
    int base, n;
    @(posedge clk); #2; res_ready = 0;
    base = en_count;
    push(24'($urandom), 12'($urandom), 2'b11, 4'd7);
    cmd_idle;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 10);
    checks += 2;
    if (n != 2) begin errors++; $display("FAIL illegal_latency got %0d required 2", n); end
    if ({res_tag, res_count, res_err} !== {4'd7, 8'd0, 1'b1}) begin
      errors++; $display("FAIL illegal_result got %h required %h", {res_tag, res_count, res_err}, {4'd7, 8'd0, 1'b1});
    end
    wait_drain("illegal");
    checks++;
    if (en_count != base) begin errors++; $display("FAIL illegal_no_en got %0d pulses required 0", en_count - base); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    bit ok;
    @(posedge clk); #2; res_ready = 0; got_tags.delete();
    @(negedge clk); core_hold = 1;
    for (int i = 0; i < 4; i++) push(24'($urandom), 12'($urandom), 2'($urandom_range(0, 2)), TAG_W'(i));
    @(posedge clk); #2;
    cmd_central = 24'($urandom); cmd_radius = 12'($urandom); cmd_mode = 2'b01; cmd_tag = 4'd4;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full cmd_ready got %b required 0", cmd_ready); end
    core_hold = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (cmd_ready) model_push(cmd_central, cmd_radius, cmd_mode, cmd_tag);
    cmd_idle;
    wait_drain("b2b");
    ok = (got_tags.size() == 5);
    for (int i = 0; i < got_tags.size() && i < 5; i++) if (got_tags[i] != TAG_W'(i)) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_order got %0d results %p required tags 0..4", got_tags.size(), got_tags); end
  endtask

  task automatic test_hold;
    int n = 0, en_seen = 0, dropped = 0;
    @(posedge clk); #2; res_ready = 0; core_lat = 5;
    push(24'($urandom), 12'($urandom), 2'b00, 4'd1);
    push(24'($urandom), 12'($urandom), 2'b01, 4'd2);
    cmd_idle;
    do begin @(negedge clk); n++; end while (!res_valid && n < 50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (set_en) en_seen++;
      if (!res_valid) dropped++;
    end
    checks += 2;
    if (en_seen != 0 || dropped != 0) begin
      errors++; $display("FAIL hold_no_issue en=%0d dropped=%0d required 0 and 0", en_seen, dropped);
    end
    if (res_tag !== 4'd1) begin errors++; $display("FAIL hold_tag got %0d required 1", res_tag); end
    @(posedge clk); #2; res_ready = 1;
    @(negedge clk);
    @(posedge clk); #2; res_ready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!set_en && n < 10);
    checks++;
    if (n != 2) begin errors++; $display("FAIL hold_reissue got %0d cycles required 2", n); end
    wait_drain("hold");
    core_lat = 4;
  endtask

  task automatic test_random;
    int accepted = 0, cyc = 0;
    bit taken;
    core_rand = 1;
    @(posedge clk); #2; cmd_valid = 0;
    while (accepted < 40 && cyc < 4000) begin
      res_ready = 1'($urandom_range(0, 1));
      if (!cmd_valid && $urandom_range(0, 2) != 0) begin
        cmd_valid = 1; cmd_central = 24'($urandom); cmd_radius = 12'($urandom);
        cmd_mode = 2'($urandom_range(0, 3)); cmd_tag = TAG_W'($urandom);
      end
      @(negedge clk);
      taken = cmd_valid && cmd_ready;
      if (taken) begin model_push(cmd_central, cmd_radius, cmd_mode, cmd_tag); accepted++; end
      @(posedge clk); #2;
      if (taken) cmd_valid = 0;
      cyc++;
    end
    cmd_valid = 0;
    checks++;
    if (accepted != 40) begin errors++; $display("FAIL random_accepted got %0d required 40", accepted); end
    wait_drain("random");
    core_rand = 0;
  endtask

  task automatic test_reset_mid;
    int n = 0, bad = 0;
    @(posedge clk); #2; res_ready = 1; core_lat = 50;
    for (int i = 0; i < 3; i++) push(24'($urandom), 12'($urandom), 2'($urandom_range(0, 2)), TAG_W'(8 + i));
    cmd_idle;
    do begin @(negedge clk); n++; end while (!set_en && n < 20);
    repeat (5) @(negedge clk);
    @(posedge clk); #2; rst = 1; iss_q.delete(); res_q.delete();
    @(negedge clk);
    checks++;
    if ({cmd_ready, set_en, set_central, set_radius, set_mode, res_valid, res_tag, res_count, res_err}
        !== {1'b1, {(49 + TAG_W){1'b0}}}) begin
      errors++; $display("FAIL reset_mid_outputs got %h required %h",
        {cmd_ready, set_en, set_central, set_radius, set_mode, res_valid, res_tag, res_count, res_err},
        {1'b1, {(49 + TAG_W){1'b0}}});
    end
    @(posedge clk); #2; rst = 0;
    repeat (20) begin @(negedge clk); if (set_en || res_valid || !cmd_ready) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_empty got %0d busy cycles required 0", bad); end
    core_lat = 4;
  endtask

`ifdef SET_WDOG_EN
  task automatic test_wdog;
    int n = 0;
    @(posedge clk); #2; res_ready = 0; core_mute = 1;
    push(24'($urandom), 12'($urandom), 2'b10, 4'd5);
    void'(res_q.pop_back());
    res_q.push_back({4'd5, 8'd0, 1'b1});
    cmd_idle;
    do begin @(negedge clk); n++; end while (!set_en && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 300);
    checks += 2;
    if (n != TIMEOUT) begin errors++; $display("FAIL wdog_latency got %0d required %0d", n, TIMEOUT); end
    if ({res_tag, res_count, res_err} !== {4'd5, 8'd0, 1'b1}) begin
      errors++; $display("FAIL wdog_result got %h required %h", {res_tag, res_count, res_err}, {4'd5, 8'd0, 1'b1});
    end
    core_stray = 1;
    repeat (4) @(negedge clk);
    checks++;
    if ({res_valid, res_count, res_err} !== {1'b1, 8'd0, 1'b1}) begin
      errors++; $display("FAIL wdog_stray got %h required %h", {res_valid, res_count, res_err}, {1'b1, 8'd0, 1'b1});
    end
    core_mute = 0; core_abort = 1;
    wait_drain("wdog");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; cmd_valid = 0; cmd_central = 0; cmd_radius = 0; cmd_mode = 0; cmd_tag = 0; res_ready = 0;
    test_reset;
    test_single;
    test_illegal;
    test_back_to_back;
    test_hold;
    test_random;
    test_reset_mid;
`ifdef SET_WDOG_EN
    test_wdog;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
